matrix_result_transmitter: RTL

// Output side of the 2x2 complex matrix multiplier. Captures the 8 accumulated

---
 rtl/matrix_result_transmitter_if.sv | 23 ++
 rtl/matrix_result_transmitter.sv | 107 ++++++++++
 2 files changed

// File: rtl/matrix_result_transmitter_if.sv
// Result stream bus: one converted word per beat, tagged with row/col/imag,
// valid/ready handshake with a last-word marker.
interface matrix_result_transmitter_if #(
    parameter int OUT_WIDTH = 19
);
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_imag;
    logic                        out_row;
    logic                        out_col;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;

    modport master (
        output out_data, out_imag, out_row, out_col, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  out_data, out_imag, out_row, out_col, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/matrix_result_transmitter.sv
// Output side of the 2x2 complex matrix multiplier: captures 8 accumulated words,
// narrows them with shift + saturate and streams them out tagged {row,col,imag}.
module matrix_result_transmitter #(
    parameter int IN_WIDTH  = 40,
    parameter int FRAC_BITS = 16,
    parameter int OUT_WIDTH = 19
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*IN_WIDTH-1:0]   results_in_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overflow_o,
    matrix_result_transmitter_if.master tx
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    // Returns {saturated, narrowed word}; the arithmetic shift floors toward -inf.
    function automatic logic [OUT_WIDTH:0] convert(input logic signed [IN_WIDTH-1:0] w);
        logic signed [IN_WIDTH-1:0] s;
        s = w >>> FRAC_BITS;
        if (s > SAT_MAX)      convert = {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
        else if (s < SAT_MIN) convert = {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
        else                  convert = {1'b0, s[OUT_WIDTH-1:0]};
    endfunction

    state_t                      state_q, state_d;
    logic [2:0]                  idx_q, idx_d;
    logic signed [OUT_WIDTH-1:0] shadow_q [8];
    logic signed [OUT_WIDTH-1:0] shadow_d [8];
    logic                        overflow_q, overflow_d;
    logic [OUT_WIDTH:0]          conv [8];

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            conv[k] = convert($signed(results_in_i[k*IN_WIDTH +: IN_WIDTH]));
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        overflow_d = overflow_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_SEND;
                    idx_d      = 3'd0;
                    overflow_d = 1'b0;
                    for (int k = 0; k < 8; k++) begin
                        shadow_d[k] = conv[k][OUT_WIDTH-1:0];
                        overflow_d  = overflow_d | conv[k][OUT_WIDTH];
                    end
                end
            end
            ST_SEND: begin
                if (tx.out_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    // NOTE: the shadow array is small and explicitly zeroed on reset so out_data
    // is defined from the first cycle; larger storage would normally skip this.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            overflow_q <= 1'b0;
            for (int k = 0; k < 8; k++) shadow_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            shadow_q   <= shadow_d;
        end
    end

    always_comb begin
        tx.out_valid = (state_q == ST_SEND);
        tx.out_data  = tx.out_valid ? shadow_q[idx_q] : '0;
        tx.out_row   = tx.out_valid & idx_q[2];
        tx.out_col   = tx.out_valid & idx_q[1];
        tx.out_imag  = tx.out_valid & idx_q[0];
        tx.out_last  = tx.out_valid & (idx_q == 3'd7);
        busy_o       = (state_q != ST_IDLE);
        done_o       = (state_q == ST_DONE);
        overflow_o   = overflow_q;
    end
endmodule
